// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Captured-row stream between the sweeper (master) and its consumer (slave).
//   row_valid : captured row available (master -> slave)
//   row_ready : consumer accepts the row (slave -> master)
//   row_idx   : row number of the captured data, equals wxyz at capture
//   row_data  : captured function outputs f[NFUNC-1:0]
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if #(
  parameter int NFUNC = 10
);
  logic             row_valid;
  logic             row_ready;
  logic [3:0]       row_idx;
  logic [NFUNC-1:0] row_data;

  modport master (
    output row_valid,
    output row_idx,
    output row_data,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_idx,
    input  row_data,
    output row_ready
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives all 16 input rows (wxyz = 0..15) into a 4-input combinational
// function block, holds each row for SETTLE_CYCLES clocks, captures the
// function outputs, streams each captured row over a valid/ready handshake
// and accumulates a per-function count of rows where the output was 1.
//
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : begin a sweep (honoured only in IDLE or DONE)
//   busy         : high while a sweep is in progress (SETTLE/SEND)
//   done         : level, high from sweep completion until next start/rst
//   w,x,y,z      : row bits 3..0 driven to the function block
//   f            : function outputs returned from the block under test
//   row_if       : captured-row stream (master side)
//   ones_count   : per-function true-row counts, 5 bits each, [5k+4:5k]=f_k
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 3,
  parameter int NFUNC         = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   w,
  output logic                   x,
  output logic                   y,
  output logic                   z,
  input  logic [NFUNC-1:0]       f,
  truth_table_sweeper_if.master  row_if,
  output logic [5*NFUNC-1:0]     ones_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SEND   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Counter counts down to zero, so a reload of SETTLE_CYCLES-1 gives
  // exactly SETTLE_CYCLES edges between row change and capture.
  localparam logic [7:0] LP_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t             r_state;
  logic [3:0]         r_row;
  logic [7:0]         r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_valid;
  logic [NFUNC-1:0]   r_data;
  logic [5*NFUNC-1:0] r_ones;

  // Sweep sequencer: row stepping, settle timing, capture and counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_row   <= 4'd0;
      r_cnt   <= 8'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ones  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_row   <= 4'd0;
            r_cnt   <= LP_SETTLE_LOAD;
            r_ones  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (r_cnt == 8'd0) begin
            // f is only looked at on this edge; glitches elsewhere are ignored.
            r_data  <= f;
            r_valid <= 1'b1;
            for (int k = 0; k < NFUNC; k++) begin
              // 16 rows max into 5 bits: the sum can never wrap.
              r_ones[5*k +: 5] <= r_ones[5*k +: 5] + {4'b0000, f[k]};
            end
            r_state <= ST_SEND;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        ST_SEND: begin
          // Row, data and valid stay frozen until the consumer accepts.
          if (r_valid && row_if.row_ready) begin
            r_valid <= 1'b0;
            if (r_row == 4'd15) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_row   <= r_row + 4'd1;
              r_cnt   <= LP_SETTLE_LOAD;
              r_state <= ST_SETTLE;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_row   <= 4'd0;
          r_cnt   <= 8'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_valid <= 1'b0;
          r_data  <= '0;
          r_ones  <= '0;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign w               = r_row[3];
  assign x               = r_row[2];
  assign y               = r_row[1];
  assign z               = r_row[0];
  assign row_if.row_valid = r_valid;
  assign row_if.row_idx   = r_row;
  assign row_if.row_data  = r_data;
  assign ones_count      = r_ones;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Two sweepers (SETTLE_CYCLES=3 and =1) share clock and reset. Each drives a
// behavioural function block selected by f_mode: 0 = sum-of-products block
// (f2, f3), 1 = wxyz parity registered twice, 2 = all ones. Expected rows
// are queued when a sweep is launched and popped at every handshake.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  typedef struct {
    logic [3:0] idx;
    logic [9:0] data;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    = 1'b1;
  logic [1:0] f_mode = 2'd0;
  logic       start3 = 1'b0;
  logic       start1 = 1'b0;

  logic        busy3, done3, w3, x3, y3, z3;
  logic        busy1, done1, w1, x1, y1, z1;
  logic [9:0]  f3_s, f1_s;
  logic [49:0] oc3, oc1;
  logic        p3a = 1'b0, p3b = 1'b0, p1a = 1'b0, p1b = 1'b0;

  int   n_vec  = 0;
  int   n_err  = 0;
  int   mism1  = 0;
  logic [9:0] last_data3 = 10'd0;
  row_t sb3[$];

  truth_table_sweeper_if #(.NFUNC(10)) bus3 ();
  truth_table_sweeper_if #(.NFUNC(10)) bus1 ();

  truth_table_sweeper #(.SETTLE_CYCLES(3), .NFUNC(10)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
    .w(w3), .x(x3), .y(y3), .z(z3), .f(f3_s), .row_if(bus3), .ones_count(oc3)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .NFUNC(10)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .w(w1), .x(x1), .y(y1), .z(z1), .f(f1_s), .row_if(bus1), .ones_count(oc1)
  );

  // Function block under evaluation, written literally as sum of products.
  function automatic logic [9:0] fblk(input logic w, x, y, z);
    logic [9:0] r;
    r    = 10'd0;
    r[2] = (z & w & x) | (y & w & x) | (y & z & w) | (y & z & x);
    r[3] = (y & x) | (z & w);
    return r;
  endfunction

  // Parity source delayed two clocks behind wxyz.
  always @(posedge clk) begin
    p3a <= w3 ^ x3 ^ y3 ^ z3;
    p3b <= p3a;
    p1a <= w1 ^ x1 ^ y1 ^ z1;
    p1b <= p1a;
  end

  assign f3_s = (f_mode == 2'd0) ? fblk(w3, x3, y3, z3) :
                (f_mode == 2'd1) ? {9'd0, p3b} : 10'h3FF;
  assign f1_s = (f_mode == 2'd0) ? fblk(w1, x1, y1, z1) :
                (f_mode == 2'd1) ? {9'd0, p1b} : 10'h3FF;

  // Expected row from row number, stated independently of fblk.
  function automatic logic [9:0] exp_row(input int mode, input int r);
    logic [3:0] b;
    logic [9:0] e;
    b = 4'(r);
    e = 10'd0;
    case (mode)
      0: begin
        e[2] = ($countones(b) >= 3);           // majority of w,x,y,z
        e[3] = (b[2] & b[1]) | (b[3] & b[0]);  // xy | wz
      end
      1: e[0] = ^b;
      default: e = 10'h3FF;
    endcase
    return e;
  endfunction

  function automatic logic [49:0] exp_counts(input int mode);
    int c[10];
    logic [9:0]  e;
    logic [49:0] res;
    for (int k = 0; k < 10; k++) c[k] = 0;
    for (int r = 0; r < 16; r++) begin
      e = exp_row(mode, r);
      for (int k = 0; k < 10; k++) c[k] += int'(e[k]);
    end
    res = 50'd0;
    for (int k = 0; k < 10; k++) res[5*k +: 5] = 5'(c[k]);
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int mode);
    row_t e;
    for (int r = 0; r < 16; r++) begin
      e.idx  = 4'(r);
      e.data = exp_row(mode, r);
      sb3.push_back(e);
    end
  endtask

  task automatic pulse_start3();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
  endtask

  task automatic wait_done3(input int c0, output int cyc);
    cyc = c0;
    do begin
      tick();
      cyc++;
    end while (!done3 && cyc < 2000);
    check("done3_reached", done3, 1'b1);
  endtask

  task automatic wait_done1(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done1 && cyc < 2000);
    check("done1_reached", done1, 1'b1);
  endtask

  // Waits until dut3 is settling on row r (bounded).
  task automatic wait_row3(input logic [3:0] r);
    int n;
    n = 0;
    while (!({w3, x3, y3, z3} == r && !bus3.row_valid) && n < 500) begin
      tick();
      n++;
    end
    check("wait_row3", {w3, x3, y3, z3}, r);
  endtask

  // Scoreboard: every accepted dut3 row is popped and compared.
  always @(negedge clk) begin
    row_t e;
    if (!rst && bus3.row_valid && bus3.row_ready) begin
      check("sb3_has_entry", (sb3.size() > 0), 1'b1);
      if (sb3.size() > 0) begin
        e = sb3.pop_front();
        check("row_idx", bus3.row_idx, e.idx);
        check("row_data", bus3.row_data, e.data);
        check("wxyz_eq_idx", {w3, x3, y3, z3}, e.idx);
      end
      last_data3 <= bus3.row_data;
    end
  end

  // Parity mismatch counter for the short-settle sweeper.
  always @(negedge clk) begin
    if (!rst && bus1.row_valid && bus1.row_ready && f_mode == 2'd1) begin
      if (bus1.row_data != {9'd0, ^bus1.row_idx}) mism1++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus3.row_ready = 1'b1;
    bus1.row_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state.
    check("rst_flags", {busy3, done3, bus3.row_valid}, 3'b000);
    check("rst_wxyz", {w3, x3, y3, z3}, 4'd0);
    check("rst_idx_data", {bus3.row_idx, bus3.row_data}, 14'd0);
    check("rst_ones", oc3, 50'd0);

    // Main sweep with timing.
    f_mode = 2'd0;
    push_sweep(0);
    pulse_start3();
    check("busy_after_start", busy3, 1'b1);
    tick(); check("valid_E1", bus3.row_valid, 1'b0);
    tick(); check("valid_E2", bus3.row_valid, 1'b0);
    tick(); check("valid_E3", {bus3.row_valid, bus3.row_idx}, {1'b1, 4'd0});
    wait_done3(3, cyc);
    check("sweep_cycles", cyc, 64);
    check("ones_f2", oc3[14:10], 5'd5);
    check("ones_f3", oc3[19:15], 5'd7);
    check("ones_all", oc3, exp_counts(0));
    check("row15_data", last_data3[3:2], 2'b11);
    check("sb3_drained", sb3.size(), 0);
    check("busy_in_done", busy3, 1'b0);

    // Restart from DONE, with backpressure at row 6.
    push_sweep(0);
    pulse_start3();
    check("restart_done_clr", done3, 1'b0);
    check("restart_ones_clr", oc3, 50'd0);
    check("restart_row0", {w3, x3, y3, z3}, 4'd0);
    wait_row3(4'd6);
    bus3.row_ready = 1'b0;
    cyc = 0;
    while (!bus3.row_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_stable",
            {bus3.row_valid, bus3.row_idx, bus3.row_data, w3, x3, y3, z3},
            {1'b1, 4'd6, exp_row(0, 6), 4'd6});
      tick();
    end
    bus3.row_ready = 1'b1;
    tick();
    check("resume_one_edge", {bus3.row_valid, w3, x3, y3, z3}, {1'b0, 4'd7});
    wait_done3(0, cyc);
    check("stall_ones", oc3, exp_counts(0));

    // Start while busy is ignored.
    push_sweep(0);
    pulse_start3();
    wait_row3(4'd9);
    pulse_start3();
    check("busy_start_ignored", {busy3, w3, x3, y3, z3}, {1'b1, 4'd9});
    wait_done3(0, cyc);
    check("busy_start_ones", oc3, exp_counts(0));
    check("sb3_drained2", sb3.size(), 0);

    // Settle timing with delayed parity source.
    f_mode = 2'd1;
    push_sweep(1);
    pulse_start3();
    wait_done3(0, cyc);
    check("parity_ones", oc3, exp_counts(1));

    // Reset in the middle of a sweep.
    f_mode = 2'd0;
    push_sweep(0);
    pulse_start3();
    wait_row3(4'd4);
    rst = 1'b1;
    tick();
    check("midrst_flags", {busy3, done3, bus3.row_valid}, 3'b000);
    check("midrst_wxyz", {w3, x3, y3, z3}, 4'd0);
    check("midrst_idx_data", {bus3.row_idx, bus3.row_data}, 14'd0);
    check("midrst_ones", oc3, 50'd0);
    sb3.delete();
    rst = 1'b0;
    tick();
    check("midrst_idle", {busy3, done3}, 2'b00);
    push_sweep(0);
    pulse_start3();
    wait_done3(0, cyc);
    check("midrst_sweep_cycles", cyc, 64);
    check("midrst_ones_after", oc3, exp_counts(0));
    check("sb3_drained3", sb3.size(), 0);

    // Too-short settle must capture stale parity.
    f_mode = 2'd1;
    mism1 = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done1(cyc);
    check("short_settle_mism", (mism1 > 0), 1'b1);

    // All ones, one-cycle settle.
    f_mode = 2'd2;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done1(cyc);
    check("ones_sweep_cycles", cyc, 32);
    for (int k = 0; k < 10; k++) begin
      check("ones_field16", oc1[5*k +: 5], 5'b10000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
